// File: rtl/mem_pkg.sv
// Shared constants, FSM encoding and response record
// for the dual-issue memory access unit.
package mem_pkg;

  localparam int DEPTH = 1000;
  localparam int TAG_W = 5;

  typedef enum logic {
    FLOW = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             fwd;
    logic [31:0]      fwd_data;
    logic             zero;
  } resp_t;

  function automatic logic in_range(
    input logic [31:0] addr
  );
    return addr < 32'(DEPTH);
  endfunction

endpackage

// File: rtl/mem_resp_slot.sv
// One response lane: stage register, writeback hold
// register and the result data mux.
module mem_resp_slot
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             take,
  input  logic [TAG_W-1:0] tag,
  input  logic             fwd,
  input  logic [31:0]      fwd_data,
  input  logic             zero,
  input  logic [31:0]      rd,
  input  logic             cap,
  input  logic             rel,
  input  logic             use_hold,
  output logic             stage_valid,
  output logic             wb_valid,
  output logic [31:0]      wb_data,
  output logic [TAG_W-1:0] wb_tag
);

  resp_t            stg;
  logic             hv;
  logic [31:0]      hd;
  logic [TAG_W-1:0] ht;
  logic [31:0]      sdata;

  always_comb begin
    sdata = rd;
    if (stg.zero)
      sdata = '0;
    else if (stg.fwd)
      sdata = stg.fwd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg <= '0;
      hv  <= 1'b0;
      hd  <= '0;
      ht  <= '0;
    end else begin
      stg.valid <= take;
      if (take) begin
        stg.tag      <= tag;
        stg.fwd      <= fwd;
        stg.fwd_data <= fwd_data;
        stg.zero     <= zero;
      end
      // rd is only valid this cycle, so the muxed value is frozen
      if (cap) begin
        hv <= stg.valid;
        hd <= sdata;
        ht <= stg.tag;
      end else if (rel) begin
        hv <= 1'b0;
      end
    end
  end

  assign stage_valid = stg.valid;
  assign wb_valid    = use_hold ? hv : stg.valid;
  assign wb_data     = use_hold ? hd : sdata;
  assign wb_tag      = use_hold ? ht : stg.tag;

endmodule

// File: rtl/mem_access_unit.sv
// Dual-issue load/store requester for a dual-port data
// memory with same-address hazard resolution.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Iss0_valid,
  input  logic             Iss1_valid,
  input  logic             Iss0_load,
  input  logic             Iss1_load,
  input  logic             Iss0_store,
  input  logic             Iss1_store,
  input  logic [31:0]      Iss0_addr,
  input  logic [31:0]      Iss1_addr,
  input  logic [31:0]      Iss0_wdata,
  input  logic [31:0]      Iss1_wdata,
  input  logic [TAG_W-1:0] Iss0_tag,
  input  logic [TAG_W-1:0] Iss1_tag,
  output logic             Iss_ready,
  output logic             RE1,
  output logic             RE2,
  output logic             WE1,
  output logic             WE2,
  output logic [31:0]      A1,
  output logic [31:0]      A2,
  output logic [31:0]      WD1,
  output logic [31:0]      WD2,
  input  logic [31:0]      RD1,
  input  logic [31:0]      RD2,
  output logic             Wb0_valid,
  output logic             Wb1_valid,
  output logic [31:0]      Wb0_data,
  output logic [31:0]      Wb1_data,
  output logic [TAG_W-1:0] Wb0_tag,
  output logic [TAG_W-1:0] Wb1_tag,
  input  logic             Wb_ready,
  output logic             Fault
);

  state_t state;
  logic   sv0, sv1, pend, flow;
  logic   acc0, acc1, ld0, ld1, st0, st1;
  logic   ok0, ok1, same, ww, fw;
  logic   go_hold, rel;

  assign flow = (state == FLOW);
  assign pend = sv0 | sv1;
  assign Iss_ready = flow && (!pend || Wb_ready);

  assign acc0 = Iss_ready && Iss0_valid
             && (Iss0_load || Iss0_store);
  assign acc1 = Iss_ready && Iss1_valid
             && (Iss1_load || Iss1_store);
  assign ld0 = acc0 && Iss0_load;
  assign ld1 = acc1 && Iss1_load;
  assign st0 = acc0 && Iss0_store && !Iss0_load;
  assign st1 = acc1 && Iss1_store && !Iss1_load;
  assign ok0 = in_range(Iss0_addr);
  assign ok1 = in_range(Iss1_addr);

  assign same = acc0 && acc1 && (Iss0_addr == Iss1_addr);
  assign ww   = same && st0 && st1;
  assign fw   = same && st0 && ld1;

  assign RE1 = ld0 && ok0;
  assign WE1 = st0 && ok0 && !ww;
  assign RE2 = ld1 && ok1 && !fw;
  assign WE2 = st1 && ok1;
  assign A1  = (acc0 && ok0) ? Iss0_addr  : '0;
  assign A2  = (acc1 && ok1) ? Iss1_addr  : '0;
  assign WD1 = (st0 && ok0)  ? Iss0_wdata : '0;
  assign WD2 = (st1 && ok1)  ? Iss1_wdata : '0;

  assign go_hold = flow && pend && !Wb_ready;
  assign rel     = !flow && Wb_ready;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= FLOW;
      Fault <= 1'b0;
    end else begin
      Fault <= (acc0 && !ok0) || (acc1 && !ok1);
      unique case (state)
        FLOW: if (go_hold) state <= HOLD;
        HOLD: if (Wb_ready) state <= FLOW;
        default: state <= FLOW;
      endcase
    end
  end

  mem_resp_slot u_slot0 (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .take        (ld0),
    .tag         (Iss0_tag),
    .fwd         (1'b0),
    .fwd_data    (32'd0),
    .zero        (!ok0),
    .rd          (RD1),
    .cap         (go_hold),
    .rel         (rel),
    .use_hold    (!flow),
    .stage_valid (sv0),
    .wb_valid    (Wb0_valid),
    .wb_data     (Wb0_data),
    .wb_tag      (Wb0_tag)
  );

  mem_resp_slot u_slot1 (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .take        (ld1),
    .tag         (Iss1_tag),
    .fwd         (fw),
    .fwd_data    (Iss0_wdata),
    .zero        (!ok1),
    .rd          (RD2),
    .cap         (go_hold),
    .rel         (rel),
    .use_hold    (!flow),
    .stage_valid (sv1),
    .wb_valid    (Wb1_valid),
    .wb_data     (Wb1_data),
    .wb_tag      (Wb1_tag)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural
// dual-port memory (read-before-write, 1-cycle read).
module tb_mem_access_unit;
  import mem_pkg::*;

  logic             Clk = 1'b0;
  logic             Rst_n;
  logic             Iss0_valid, Iss1_valid;
  logic             Iss0_load, Iss1_load;
  logic             Iss0_store, Iss1_store;
  logic [31:0]      Iss0_addr, Iss1_addr;
  logic [31:0]      Iss0_wdata, Iss1_wdata;
  logic [TAG_W-1:0] Iss0_tag, Iss1_tag;
  logic             Iss_ready;
  logic             RE1, RE2, WE1, WE2;
  logic [31:0]      A1, A2, WD1, WD2;
  logic [31:0]      RD1, RD2;
  logic             Wb0_valid, Wb1_valid;
  logic [31:0]      Wb0_data, Wb1_data;
  logic [TAG_W-1:0] Wb0_tag, Wb1_tag;
  logic             Wb_ready;
  logic             Fault;

  logic [31:0] mem [0:1023];
  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (RE1) RD1 <= mem[A1[9:0]];
    if (RE2) RD2 <= mem[A2[9:0]];
    if (WE1) mem[A1[9:0]] <= WD1;
    if (WE2) mem[A2[9:0]] <= WD2;
  end

  mem_access_unit dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Iss0_valid (Iss0_valid),
    .Iss1_valid (Iss1_valid),
    .Iss0_load  (Iss0_load),
    .Iss1_load  (Iss1_load),
    .Iss0_store (Iss0_store),
    .Iss1_store (Iss1_store),
    .Iss0_addr  (Iss0_addr),
    .Iss1_addr  (Iss1_addr),
    .Iss0_wdata (Iss0_wdata),
    .Iss1_wdata (Iss1_wdata),
    .Iss0_tag   (Iss0_tag),
    .Iss1_tag   (Iss1_tag),
    .Iss_ready  (Iss_ready),
    .RE1        (RE1),
    .RE2        (RE2),
    .WE1        (WE1),
    .WE2        (WE2),
    .A1         (A1),
    .A2         (A2),
    .WD1        (WD1),
    .WD2        (WD2),
    .RD1        (RD1),
    .RD2        (RD2),
    .Wb0_valid  (Wb0_valid),
    .Wb1_valid  (Wb1_valid),
    .Wb0_data   (Wb0_data),
    .Wb1_data   (Wb1_data),
    .Wb0_tag    (Wb0_tag),
    .Wb1_tag    (Wb1_tag),
    .Wb_ready   (Wb_ready),
    .Fault      (Fault)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    Iss0_valid = 0; Iss0_load = 0; Iss0_store = 0;
    Iss1_valid = 0; Iss1_load = 0; Iss1_store = 0;
    Iss0_addr = 0; Iss0_wdata = 0; Iss0_tag = 0;
    Iss1_addr = 0; Iss1_wdata = 0; Iss1_tag = 0;
  endtask

  task automatic op0(input logic ld, input logic st,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [TAG_W-1:0] t);
    Iss0_valid = 1; Iss0_load = ld; Iss0_store = st;
    Iss0_addr = a; Iss0_wdata = d; Iss0_tag = t;
  endtask

  task automatic op1(input logic ld, input logic st,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [TAG_W-1:0] t);
    Iss1_valid = 1; Iss1_load = ld; Iss1_store = st;
    Iss1_addr = a; Iss1_wdata = d; Iss1_tag = t;
  endtask

  // advance to the next negedge, then let inputs settle
  task automatic cyc();
    @(negedge Clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[3]  = 32'h1;
    mem[20] = 32'h55;
    RD1 = '0; RD2 = '0;
    idle();
    Wb_ready = 1;
    Rst_n = 0;
    cyc(); cyc(); #1;
    chk("rst_ready", Iss_ready, 1);
    chk("rst_wb0v", Wb0_valid, 0);
    chk("rst_wb1v", Wb1_valid, 0);
    chk("rst_fault", Fault, 0);
    chk("rst_strobes", {RE1, RE2, WE1, WE2}, 0);
    Rst_n = 1;

    // store then load through slot 0
    cyc(); op0(0, 1, 10, 32'hDEADBEEF, 0); #1;
    chk("st_we1", WE1, 1);
    chk("st_a1", A1, 10);
    chk("st_wd1", WD1, 32'hDEADBEEF);
    chk("st_re1", RE1, 0);
    cyc(); idle(); op0(1, 0, 10, 0, 3); #1;
    chk("ld_re1", RE1, 1);
    chk("st_nowb", Wb0_valid, 0);
    cyc(); idle(); #1;
    chk("ld_wb0v", Wb0_valid, 1);
    chk("ld_wb0d", Wb0_data, 32'hDEADBEEF);
    chk("ld_wb0t", Wb0_tag, 3);

    // store0 + load1 same address: forward
    cyc(); op0(0, 1, 5, 32'h11, 0); op1(1, 0, 5, 0, 7); #1;
    chk("fw_re2", RE2, 0);
    chk("fw_we1", WE1, 1);
    cyc(); idle(); #1;
    chk("fw_wb1v", Wb1_valid, 1);
    chk("fw_wb1d", Wb1_data, 32'h11);
    chk("fw_wb1t", Wb1_tag, 7);
    chk("fw_wb0v", Wb0_valid, 0);

    // store0 + store1 same address: younger wins
    cyc(); op0(0, 1, 7, 32'hAA, 0); op1(0, 1, 7, 32'hBB, 0); #1;
    chk("ww_we1", WE1, 0);
    chk("ww_we2", WE2, 1);
    chk("ww_wd2", WD2, 32'hBB);
    cyc(); idle(); op0(1, 0, 7, 0, 1); #1;

    // load0 + store1 same address: old value read
    cyc(); idle(); op0(1, 0, 3, 0, 2); op1(0, 1, 3, 32'h2, 0); #1;
    chk("ww_rd7", Wb0_data, 32'hBB);
    chk("ww_rd7t", Wb0_tag, 1);
    chk("lw_re1", RE1, 1);
    chk("lw_we2", WE2, 1);
    cyc(); idle(); op0(1, 0, 3, 0, 4); #1;
    chk("lw_old", Wb0_data, 32'h1);
    chk("lw_oldt", Wb0_tag, 2);
    chk("lw_wb1v", Wb1_valid, 0);
    cyc(); idle(); #1;
    chk("lw_new", Wb0_data, 32'h2);
    chk("lw_newt", Wb0_tag, 4);

    // writeback back-pressure
    cyc(); op0(1, 0, 20, 0, 9); #1;
    chk("bp_re1", RE1, 1);
    cyc(); idle(); Wb_ready = 0; op0(1, 0, 10, 0, 8); #1;
    chk("bp0_rdy", Iss_ready, 0);
    chk("bp0_v", Wb0_valid, 1);
    chk("bp0_d", Wb0_data, 32'h55);
    chk("bp0_re1", RE1, 0);
    for (int i = 1; i < 3; i++) begin
      cyc(); #1;
      chk("bph_rdy", Iss_ready, 0);
      chk("bph_v", Wb0_valid, 1);
      chk("bph_d", Wb0_data, 32'h55);
      chk("bph_t", Wb0_tag, 9);
      chk("bph_strb", {RE1, RE2, WE1, WE2}, 0);
    end
    cyc(); Wb_ready = 1; #1;
    chk("bpr_rdy", Iss_ready, 0);
    chk("bpr_d", Wb0_data, 32'h55);
    chk("bpr_re1", RE1, 0);
    cyc(); idle(); #1;
    chk("bpe_rdy", Iss_ready, 1);
    chk("bpe_v", Wb0_valid, 0);

    // out-of-range boundary
    cyc(); op0(1, 0, 1000, 0, 5); op1(0, 1, 2000, 32'h77, 0); #1;
    chk("oor_re1", RE1, 0);
    chk("oor_we2", WE2, 0);
    chk("oor_rdy", Iss_ready, 1);
    cyc(); idle(); #1;
    chk("oor_fault", Fault, 1);
    chk("oor_v", Wb0_valid, 1);
    chk("oor_d", Wb0_data, 0);
    chk("oor_t", Wb0_tag, 5);
    cyc(); op0(1, 0, 999, 0, 6); #1;
    chk("oor_pulse", Fault, 0);
    chk("edge_re1", RE1, 1);
    cyc(); idle(); #1;
    chk("edge_fault", Fault, 0);

    // reset while holding
    cyc(); op0(1, 0, 20, 0, 6); #1;
    cyc(); idle(); Wb_ready = 0; #1;
    chk("rh_v", Wb0_valid, 1);
    cyc(); Rst_n = 0; #1;
    chk("rh_hold", Iss_ready, 0);
    cyc(); Rst_n = 1; #1;
    chk("rh_wb0v", Wb0_valid, 0);
    chk("rh_wb1v", Wb1_valid, 0);
    chk("rh_rdy", Iss_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Dual-issue load/store requester that drives both ports of the processor's dual-port data memory.
- Accepts up to two memory ops per cycle from issue slots 0 (older) and 1 (younger) and resolves same-address ordering between them.
- Absorbs the memory's one-cycle registered read latency and returns tagged load results to writeback under a ready/valid handshake, with a hold state for writeback back-pressure.

Parameters:
- DEPTH, 1000, number of 32-bit words in data memory; valid word addresses are 0..DEPTH-1.
- TAG_W, 5, width of destination-register tag.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst_n  in  1  synchronous active-low reset.
- Iss0_valid, Iss1_valid  in  1  slot carries a memory op.
- Iss0_load, Iss1_load  in  1  op is a load.
- Iss0_store, Iss1_store  in  1  op is a store; load and store both high is illegal.
- Iss0_addr, Iss1_addr  in  32  word address.
- Iss0_wdata, Iss1_wdata  in  32  store data.
- Iss0_tag, Iss1_tag  in  TAG_W  load destination tag.
- Iss_ready  out  1  unit accepts the issue pair this cycle.
- RE1, RE2, WE1, WE2  out  1  memory port strobes; port 1 serves slot 0, port 2 serves slot 1.
- A1, A2, WD1, WD2  out  32  memory address and write data.
- RD1, RD2  in  32  memory read data, valid the cycle after RE.
- Wb0_valid, Wb1_valid  out  1  load result valid, per slot.
- Wb0_data, Wb1_data  out  32  load result.
- Wb0_tag, Wb1_tag  out  TAG_W  load result tag.
- Wb_ready  in  1  writeback consumes both results this cycle.
- Fault  out  1  registered one-cycle pulse on an out-of-range access.

Behaviour:
- Accept: slot k is accepted when Iss_ready && Issk_valid && (load || store).
- Iss_ready = (state==FLOW) && (!pend || Wb_ready), where pend means a Wb output is valid.
- Strobes are combinational from accepted ops. REk = load; WEk = store; Ak = addr; WDk = wdata. All strobes are 0 when the slot is not accepted.
- Out-of-range check (addr >= DEPTH): all strobes for that slot are suppressed. Fault=1 the next cycle. If the op is a load it still returns with data 0 and its tag.
- Same-address rules, when both slots are accepted and addresses are equal:
  - store0 + store1: WE1 forced 0, so the younger store wins.
  - load0 + store1: both issued; memory reads before writing, so load0 returns the old value.
  - store0 + load1: RE2 forced 0. Slot-1 result is forwarded from Iss0_wdata through a stage register.
  - load0 + load1: both issued normally.
- Response stage, per slot, registered at the edge of acceptance: v, tag, fwd flag, fwd data, zero flag.
  - Next cycle: Wbk_valid = v.
  - Wbk_data selection, in priority order: zero flag → 0; fwd flag → fwd data; otherwise RDk.
- Latency: a load accepted in cycle N presents its result in cycle N+1.
- Stores produce no Wb output.
- FSM states:
  - FLOW: Wb outputs come from the stage registers. If pend && !Wb_ready, capture both Wb outputs (valid, data, tag) into hold registers and go to HOLD. If pend && Wb_ready, stage v clears unless a new load is accepted.
  - HOLD: Wb outputs come from the hold registers; Iss_ready=0 and no strobes. When Wb_ready=1, clear hold valids and go to FLOW.
- Reset (Rst_n=0 at posedge): state=FLOW; stage and hold valids=0; Fault=0; data and tag registers cleared to 0.
  - Because the strobes are gated by acceptance, every strobe is 0 in the cycle after reset, and the unit is ready (Iss_ready=1) with no pending results.
  - A reset during HOLD discards the held results.
- A store and a load to the same address in consecutive cycles need no special handling: the memory write completes at the first edge.

Decomposition:
- Shared package mem_pkg: DEPTH, TAG_W, FSM state encoding (FLOW, HOLD), and a response record {valid, tag, fwd, fwd_data, zero}.
- One natural sub-module, mem_resp_slot: the per-slot stage register plus hold register and data mux. Instantiate it twice.
- The top level keeps the hazard logic, out-of-range check and FSM.

Test Plan:
- Store 0xDEADBEEF to addr 10 via slot 0, then load addr 10 via slot 0 next cycle → Wb0_valid=1 one cycle after the load, data 0xDEADBEEF, tag matches.
- Same cycle: slot0 store 0x11 to addr 5, slot1 load addr 5 → RE2=0; the next cycle Wb1_data=0x11.
- Same cycle: slot0 store 0xAA, slot1 store 0xBB, both to addr 7 → WE1=0, WE2=1; a later load of addr 7 returns 0xBB.
- Same cycle, memory addr 3 preloaded with 0x1: slot0 load addr 3, slot1 store 0x2 to addr 3 → Wb0_data=0x1; a later load returns 0x2.
- Load addr 20 (contains 0x55) with Wb_ready=0 for 3 cycles → Iss_ready=0 throughout, Wb0_data stays 0x55 while a new op is presented on the issue inputs, and no strobes fire. When Wb_ready=1 the result is consumed, and the next cycle Iss_ready=1.
- Load addr 1000 with DEPTH=1000 → RE1=0; the next cycle Fault=1 and Wb0_data=0. Also: assert Rst_n=0 during HOLD → the next cycle Wb valids=0 and Iss_ready=1.
